// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- memory-access pipeline stage (between EX and WB).
//
// Takes an instruction from EX, waits for load data if needed, extracts and
// extends the addressed byte/halfword/word, and hands the finished
// result to WB. It also drives a forwarding bus and a block flag for decode.
// The flag tells decode that the result is not ready yet.
//
// Handshake (valid/ready, used on both sides):
//   A transfer happens on a rising clk edge where the producer's valid and
//   the consumer's allowin are both 1. Valid must not depend on allowin.
//   The payload is only meaningful while valid is 1.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   ms_allowin          MEM can take an instruction from EX this cycle
//   es_to_ms_valid/bus  instruction from EX
//                       {ld_type[2:0], res_from_mem, gr_we, dest[4:0],
//                        alu_result[31:0], pc[31:0]}
//   ws_allowin          WB can take an instruction this cycle
//   ms_to_ws_valid/bus  completed instruction to WB
//                       {gr_we, dest[4:0], final_result[31:0], pc[31:0]}
//   data_sram_data_ok   load read data is valid this cycle
//   data_sram_rdata     load read data
//   ms_fwd_bus          bypass to decode {we, dest[4:0], result[31:0]}
//   ms_fwd_blk          MEM holds a load whose data has not arrived yet
// ---------------------------------------------------------------------------
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    output logic        ms_allowin,
    input  logic        es_to_ms_valid,
    input  logic [73:0] es_to_ms_bus,
    input  logic        ws_allowin,
    output logic        ms_to_ws_valid,
    output logic [69:0] ms_to_ws_bus,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic [37:0] ms_fwd_bus,
    output logic        ms_fwd_blk
);

    logic        ms_valid;
    logic [73:0] ms_bus_r;
    logic        buf_valid;
    logic [31:0] buf_data;

    logic [2:0]  ld_type;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    logic        ms_ready_go;
    logic        ms_leave;
    logic [31:0] raw_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_result;
    logic [31:0] final_result;

    assign {ld_type, res_from_mem, gr_we, dest, alu_result, pc} = ms_bus_r;

    // A load can only complete once its data shows up, either this cycle
    // from the SRAM or from an earlier cycle held in the buffer.
    assign ms_ready_go    = res_from_mem ? (data_sram_data_ok || buf_valid) : 1'b1;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign ms_leave       = ms_valid && ms_ready_go && ws_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin) begin
            ms_bus_r <= es_to_ms_bus;
        end
    end

    // The SRAM presents data_ok for one cycle only. If WB stalls in that
    // cycle, the word is kept here until the instruction can leave. Once
    // buffered, later data_ok pulses are ignored and the word is not
    // overwritten. Leaving takes priority over capturing.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
        end else if (ms_leave) begin
            buf_valid <= 1'b0;
        end else if (ms_valid && res_from_mem && data_sram_data_ok && !buf_valid) begin
            buf_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ms_valid && res_from_mem && data_sram_data_ok && !buf_valid && !ws_allowin) begin
            buf_data <= data_sram_rdata;
        end
    end

    assign raw_word = buf_valid ? buf_data : data_sram_rdata;

    always_comb begin
        ld_byte = raw_word[7:0];
        case (alu_result[1:0])
            2'b00:   ld_byte = raw_word[7:0];
            2'b01:   ld_byte = raw_word[15:8];
            2'b10:   ld_byte = raw_word[23:16];
            default: ld_byte = raw_word[31:24];
        endcase
        // alu_result[0] does not matter for halfword loads.
        ld_half = alu_result[1] ? raw_word[31:16] : raw_word[15:0];
    end

    always_comb begin
        ld_result = raw_word;
        case (ld_type)
            3'b001:  ld_result = {{24{ld_byte[7]}}, ld_byte};
            3'b010:  ld_result = {{16{ld_half[15]}}, ld_half};
            3'b011:  ld_result = {24'd0, ld_byte};
            3'b100:  ld_result = {16'd0, ld_half};
            default: ld_result = raw_word;
        endcase
    end

    assign final_result = res_from_mem ? ld_result : alu_result;

    assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
    assign ms_fwd_bus   = {ms_valid && gr_we && (dest != 5'd0), dest, final_result};
    assign ms_fwd_blk   = ms_valid && res_from_mem && !ms_ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage.
//
// Inputs are driven 1 ns after the rising edge. Outputs are sampled on the
// falling edge. Every instruction that should reach WB pushes its expected
// ms_to_ws_bus value into exp_q. The monitor pops the queue and compares on
// each WB transfer. The stimulus process checks the stage-level flags
// directly.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [73:0] es_to_ms_bus;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [37:0] ms_fwd_bus;
    logic        ms_fwd_blk;

    logic [69:0] exp_q[$];
    int          n_pass  = 0;
    int          n_total = 0;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_fwd_bus        (ms_fwd_bus),
        .ms_fwd_blk        (ms_fwd_blk)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [73:0] mk_es(input logic [2:0] lt, input logic rfm, input logic we,
                                          input logic [4:0] d, input logic [31:0] alu,
                                          input logic [31:0] pc);
        return {lt, rfm, we, d, alu, pc};
    endfunction

    function automatic logic [69:0] mk_ws(input logic we, input logic [4:0] d,
                                          input logic [31:0] res, input logic [31:0] pc);
        return {we, d, res, pc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Stage is idle: nothing to WB, nothing to forward, ready for EX.
    task automatic check_idle(input string tag);
        sample();
        check({tag, "_to_ws_valid"}, 70'(ms_to_ws_valid), 70'(0));
        check({tag, "_fwd_we"},      70'(ms_fwd_bus[37]), 70'(0));
        check({tag, "_fwd_blk"},     70'(ms_fwd_blk),     70'(0));
        check({tag, "_allowin"},     70'(ms_allowin),     70'(1));
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [73:0] bus);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = bus;
        step();
        es_to_ms_valid = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (ms_to_ws_valid && ws_allowin) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", ms_to_ws_bus, 70'(0));
                if (ms_to_ws_bus == 70'(0)) begin
                    // An all-zero payload would otherwise look like a match.
                    n_pass--;
                    $display("FAIL wb_unexpected: got transfer expected none");
                end
            end else begin
                check("wb_bus", ms_to_ws_bus, exp_q.pop_front());
            end
        end
    end

    // ---------------- load vector table ----------------
    logic [2:0]  lt_tab  [12] = '{3'b001, 3'b011, 3'b100, 3'b010, 3'b000, 3'b001,
                                  3'b001, 3'b011, 3'b010, 3'b101, 3'b111, 3'b100};
    logic [1:0]  lo_tab  [12] = '{2'b01, 2'b01, 2'b11, 2'b10, 2'b11, 2'b00,
                                  2'b11, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
    logic [31:0] rd_tab  [12] = '{32'h000080FF, 32'h000080FF, 32'h9ABC0000, 32'h9ABC0000,
                                  32'h13579BDF, 32'h12345678, 32'hF1000000, 32'h00AB0000,
                                  32'h00007FFF, 32'hCAFE0123, 32'h80000001, 32'hFFFF8001};
    logic [31:0] exp_tab [12] = '{32'hFFFFFF80, 32'h00000080, 32'h00009ABC, 32'hFFFF9ABC,
                                  32'h13579BDF, 32'h00000078, 32'hFFFFFFF1, 32'h000000AB,
                                  32'h00007FFF, 32'hCAFE0123, 32'h80000001, 32'h00008001};

    // ---------------- stimulus ----------------
    initial begin
        reset             = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        ws_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;

        step();
        check_idle("rst");
        step();
        reset = 1'b0;
        check_idle("post_rst");
        step();

        // Non-load add, leaves one cycle after entry.
        issue(mk_es(3'b000, 1'b0, 1'b1, 5'd5, 32'h12345678, 32'h1c000000));
        exp_q.push_back(mk_ws(1'b1, 5'd5, 32'h12345678, 32'h1c000000));
        sample();
        check("add_to_ws_valid", 70'(ms_to_ws_valid), 70'(1));
        check("add_fwd", 70'(ms_fwd_bus), 70'({1'b1, 5'd5, 32'h12345678}));
        check("add_fwd_blk", 70'(ms_fwd_blk), 70'(0));
        step();
        check_idle("add_gone");
        step();

        // Write to r0: still goes to WB, but is not forwarded.
        issue(mk_es(3'b000, 1'b0, 1'b1, 5'd0, 32'hA5A5A5A5, 32'h1c000008));
        exp_q.push_back(mk_ws(1'b1, 5'd0, 32'hA5A5A5A5, 32'h1c000008));
        sample();
        check("r0_fwd_we", 70'(ms_fwd_bus[37]), 70'(0));
        step();

        // Loads with data_ok in the entry cycle.
        for (int i = 0; i < 12; i++) begin
            logic [31:0] alu;
            logic [31:0] pc;
            logic [4:0]  d;
            alu = {30'h00000400, lo_tab[i]};
            pc  = 32'h1c000100 + 32'(i) * 4;
            d   = 5'(i + 12);
            issue(mk_es(lt_tab[i], 1'b1, 1'b1, d, alu, pc));
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = rd_tab[i];
            exp_q.push_back(mk_ws(1'b1, d, exp_tab[i], pc));
            sample();
            check($sformatf("ld%0d_to_ws_valid", i), 70'(ms_to_ws_valid), 70'(1));
            check($sformatf("ld%0d_fwd", i), 70'(ms_fwd_bus), 70'({1'b1, d, exp_tab[i]}));
            step();
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = 32'h0;
        end

        // Late load: data arrives after 3 cycles; a following add waits in EX.
        issue(mk_es(3'b000, 1'b1, 1'b1, 5'd8, 32'h00000100, 32'h1c000200));
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(3'b000, 1'b0, 1'b1, 5'd9, 32'h0BADF00D, 32'h1c000204);
        for (int c = 0; c < 3; c++) begin
            sample();
            check($sformatf("late%0d_fwd_blk", c), 70'(ms_fwd_blk), 70'(1));
            check($sformatf("late%0d_to_ws_valid", c), 70'(ms_to_ws_valid), 70'(0));
            check($sformatf("late%0d_allowin", c), 70'(ms_allowin), 70'(0));
            step();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h55AA55AA;
        exp_q.push_back(mk_ws(1'b1, 5'd8, 32'h55AA55AA, 32'h1c000200));
        exp_q.push_back(mk_ws(1'b1, 5'd9, 32'h0BADF00D, 32'h1c000204));
        sample();
        check("late_done_valid", 70'(ms_to_ws_valid), 70'(1));
        check("late_done_allowin", 70'(ms_allowin), 70'(1));
        step();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        sample();
        check("late_next_valid", 70'(ms_to_ws_valid), 70'(1));
        step();

        // WB backpressure: data is buffered and survives rdata changes.
        ws_allowin = 1'b0;
        issue(mk_es(3'b000, 1'b1, 1'b1, 5'd10, 32'h00000200, 32'h1c000300));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEADBEEF;
        sample();
        check("bp_allowin", 70'(ms_allowin), 70'(0));
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        sample();
        check("bp_buf_valid", 70'(ms_to_ws_valid), 70'(1));
        check("bp_buf_fwd", 70'(ms_fwd_bus), 70'({1'b1, 5'd10, 32'hDEADBEEF}));
        check("bp_buf_blk", 70'(ms_fwd_blk), 70'(0));
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h11111111;
        sample();
        check("bp_ignore_ok", 70'(ms_fwd_bus[31:0]), 70'(32'hDEADBEEF));
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        ws_allowin        = 1'b1;
        exp_q.push_back(mk_ws(1'b1, 5'd10, 32'hDEADBEEF, 32'h1c000300));
        step();
        // Buffer must be empty: a new load waits for its own data.
        issue(mk_es(3'b000, 1'b1, 1'b1, 5'd11, 32'h00000300, 32'h1c000304));
        sample();
        check("bp_buf_cleared_blk", 70'(ms_fwd_blk), 70'(1));
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h2468ACE0;
        exp_q.push_back(mk_ws(1'b1, 5'd11, 32'h2468ACE0, 32'h1c000304));
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;

        // Reset while a buffered load is held: it is dropped.
        ws_allowin = 1'b0;
        issue(mk_es(3'b000, 1'b1, 1'b1, 5'd12, 32'h00000400, 32'h1c000400));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h77777777;
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        sample();
        check("rl_buffered", 70'(ms_to_ws_valid), 70'(1));
        step();
        reset = 1'b1;
        step();
        reset      = 1'b0;
        ws_allowin = 1'b1;
        check_idle("rl_after");
        step();
        issue(mk_es(3'b000, 1'b1, 1'b1, 5'd13, 32'h00000500, 32'h1c000500));
        sample();
        check("rl_buf_dropped_blk", 70'(ms_fwd_blk), 70'(1));
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h3C3C3C3C;
        exp_q.push_back(mk_ws(1'b1, 5'd13, 32'h3C3C3C3C, 32'h1c000500));
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;

        step();
        step();
        check("exp_q_empty", 70'(exp_q.size()), 70'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
